pcie_link_seq_ctrl: RTL and testbench

PCIE_LINK_SEQ_CTRL -- requirements
Module: pcie_link_seq_ctrl

---
 rtl/pcie_tb_pkg.sv | 29 ++
 rtl/pcie_lane_mon.sv | 37 +++
 rtl/pcie_link_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_pcie_link_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tb_pkg.sv
// Shared definitions for the PCIe link sequencing controller: lane count,
// FSM state encodings and the configured-width lane mask helper.
package pcie_tb_pkg;

    localparam int NUM_LANES = 16;

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        WAIT_UP  = 3'd1,
        ACTIVE   = 3'd2,
        DONE     = 3'd3,
        FATAL    = 3'd4
    } linkState_t;

    // Low 'width' bits set; an out-of-range width (0 or above 16) selects every lane.
    function automatic logic [NUM_LANES-1:0] laneMask(input logic [4:0] width);
        logic [NUM_LANES-1:0] mask;
        mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (width == 5'd0 || width > 5'd16) begin
                mask[i] = 1'b1;
            end else begin
                mask[i] = (5'(i) < width);
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/pcie_lane_mon.sv
// Lane monitor: builds the active-lane mask, judges whether every configured
// lane is out of electrical idle, and counts consecutive good cycles.
module pcie_lane_mon
    import pcie_tb_pkg::*;
#(
    parameter int STABLE_CYCLES = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NUM_LANES-1:0] ElecIdleUp,
    input  logic [NUM_LANES-1:0] ElecIdleDown,
    input  logic [4:0]           LinkWidth,
    input  logic                 CountClr,
    output logic                 LaneOk,
    output logic                 StableDone
);

    logic [NUM_LANES-1:0] mask;
    logic [31:0]          stableCnt;

    assign mask   = laneMask(LinkWidth);
    assign LaneOk = ~|((ElecIdleUp | ElecIdleDown) & mask);

    // Asserted on the good cycle that completes the required run.
    assign StableDone = LaneOk && (stableCnt == 32'(STABLE_CYCLES - 1));

    always_ff @(posedge Clk) begin
        if (Reset || CountClr) begin
            stableCnt <= '0;
        end else if (LaneOk) begin
            stableCnt <= stableCnt + 32'd1;
        end else begin
            stableCnt <= '0;
        end
    end

endmodule

// File: rtl/pcie_link_seq_ctrl.sv
// Link sequencing controller: holds the vhost reset, waits for stable lanes,
// tracks link up/drop, and enforces the global timeout and test completion.
module pcie_link_seq_ctrl
    import pcie_tb_pkg::*;
#(
    parameter int RESET_CYCLES  = 10,
    parameter int STABLE_CYCLES = 8,
    parameter int TIMEOUT_COUNT = 100000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NUM_LANES-1:0] ElecIdleUp,
    input  logic [NUM_LANES-1:0] ElecIdleDown,
    input  logic [4:0]           LinkWidth,
    input  logic                 ReRstReq,
    input  logic                 DoneReq,
    output logic                 notReset,
    output logic                 LinkUp,
    output logic                 LinkDrop,
    output logic                 Fatal,
    output logic                 Finish,
    output logic [31:0]          CycleCount,
    output logic [2:0]           State
);

    linkState_t  state;
    logic [31:0] holdCnt;
    logic [31:0] cycleNext;
    logic        terminal;
    logic        timeoutHit;
    logic        reRst;
    logic        countClr;
    logic        laneOk;
    logic        stableDone;

    assign State = state;

    always_comb begin
        cycleNext  = (CycleCount == 32'hFFFF_FFFF) ? CycleCount : CycleCount + 32'd1;
        terminal   = (state == DONE) || (state == FATAL);
        timeoutHit = !terminal && (cycleNext >= 32'(TIMEOUT_COUNT));
        reRst      = !terminal && ReRstReq;
        // The stable run only accumulates while waiting and nothing overrides it.
        countClr   = (state != WAIT_UP) || timeoutHit || reRst || stableDone;
    end

    pcie_lane_mon #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_laneMon (
        .Clk          (Clk),
        .Reset        (Reset),
        .ElecIdleUp   (ElecIdleUp),
        .ElecIdleDown (ElecIdleDown),
        .LinkWidth    (LinkWidth),
        .CountClr     (countClr),
        .LaneOk       (laneOk),
        .StableDone   (stableDone)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= RST_HOLD;
            holdCnt    <= '0;
            CycleCount <= '0;
            notReset   <= 1'b0;
            LinkUp     <= 1'b0;
            LinkDrop   <= 1'b0;
            Fatal      <= 1'b0;
            Finish     <= 1'b0;
        end else begin
            CycleCount <= cycleNext;
            LinkDrop   <= 1'b0;
            if (timeoutHit) begin
                state    <= FATAL;
                Fatal    <= 1'b1;
                notReset <= 1'b0;
                LinkUp   <= 1'b0;
                holdCnt  <= '0;
            end else if (reRst) begin
                state    <= RST_HOLD;
                holdCnt  <= '0;
                notReset <= 1'b0;
                LinkUp   <= 1'b0;
            end else begin
                case (state)
                    RST_HOLD: begin
                        if (holdCnt == 32'(RESET_CYCLES - 1)) begin
                            state    <= WAIT_UP;
                            notReset <= 1'b1;
                            holdCnt  <= '0;
                        end else begin
                            holdCnt <= holdCnt + 32'd1;
                        end
                    end
                    WAIT_UP: begin
                        if (stableDone) begin
                            state  <= ACTIVE;
                            LinkUp <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        // Completion outranks a lane dropping in the same cycle.
                        if (DoneReq) begin
                            state  <= DONE;
                            Finish <= 1'b1;
                            LinkUp <= 1'b0;
                        end else if (!laneOk) begin
                            state    <= WAIT_UP;
                            LinkUp   <= 1'b0;
                            LinkDrop <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcie_link_seq_ctrl.sv
// Scoreboarded bench for pcie_link_seq_ctrl: a cycle-level reference model
// queues expected outputs and a monitor compares them after each clock edge.
module tb_pcie_link_seq_ctrl;
  import pcie_tb_pkg::*;

  localparam int RESET_CYCLES  = 10;
  localparam int STABLE_CYCLES = 8;
  localparam int TIMEOUT_COUNT = 50;
  localparam int EXP_W         = 40;

  // clock / reset block
  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] ElecIdleUp;
  logic [15:0] ElecIdleDown;
  logic [4:0]  LinkWidth;
  logic        ReRstReq;
  logic        DoneReq;
  logic        notReset;
  logic        LinkUp;
  logic        LinkDrop;
  logic        Fatal;
  logic        Finish;
  logic [31:0] CycleCount;
  logic [2:0]  State;

  always #5 Clk = ~Clk;

  pcie_link_seq_ctrl #(
    .RESET_CYCLES (RESET_CYCLES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .TIMEOUT_COUNT(TIMEOUT_COUNT)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .ElecIdleUp  (ElecIdleUp),
    .ElecIdleDown(ElecIdleDown),
    .LinkWidth   (LinkWidth),
    .ReRstReq    (ReRstReq),
    .DoneReq     (DoneReq),
    .notReset    (notReset),
    .LinkUp      (LinkUp),
    .LinkDrop    (LinkDrop),
    .Fatal       (Fatal),
    .Finish      (Finish),
    .CycleCount  (CycleCount),
    .State       (State)
  );

  // scoreboard: {notReset, LinkUp, LinkDrop, Fatal, Finish, CycleCount, State}
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int samples = 0;

  // reference model: phase names, cycles spent holding, current good-lane run
  typedef enum int { M_HOLD, M_WAIT, M_ACTIVE, M_DONE, M_FATAL } m_phase_t;
  m_phase_t    m_phase = M_HOLD;
  int          m_held = 0;
  int          m_run = 0;
  longint      m_cycles = 0;
  logic        m_nres = 0, m_up = 0, m_drop = 0, m_fatal = 0, m_finish = 0;

  function automatic logic [2:0] phase_code(input m_phase_t p);
    case (p)
      M_HOLD:   return RST_HOLD;
      M_WAIT:   return WAIT_UP;
      M_ACTIVE: return ACTIVE;
      M_DONE:   return DONE;
      default:  return FATAL;
    endcase
  endfunction

  function automatic bit lanes_good(input logic [15:0] up, input logic [15:0] dn, input logic [4:0] w);
    int mask;
    if (w == 0 || w > 16) mask = 'hFFFF;
    else mask = (1 << w) - 1;
    return ((int'(up | dn)) & mask) == 0;
  endfunction

  task automatic model_step(input logic rst, input logic [15:0] up, input logic [15:0] dn,
                            input logic [4:0] w, input logic rr, input logic dr);
    longint next_cycles;
    bit     ended;
    bit     ok;
    if (rst) begin
      m_phase = M_HOLD; m_held = 0; m_run = 0; m_cycles = 0;
      m_nres = 0; m_up = 0; m_drop = 0; m_fatal = 0; m_finish = 0;
      return;
    end
    ok = lanes_good(up, dn, w);
    next_cycles = (m_cycles == 64'hFFFF_FFFF) ? m_cycles : m_cycles + 1;
    ended = (m_phase == M_DONE) || (m_phase == M_FATAL);
    m_drop = 0;
    if (!ended && next_cycles >= TIMEOUT_COUNT) begin
      m_phase = M_FATAL; m_fatal = 1; m_nres = 0; m_up = 0;
    end else if (!ended && rr) begin
      m_phase = M_HOLD; m_held = 0; m_run = 0; m_nres = 0; m_up = 0;
    end else begin
      case (m_phase)
        M_HOLD: begin
          m_held++;
          if (m_held == RESET_CYCLES) begin
            m_phase = M_WAIT; m_nres = 1; m_run = 0;
          end
        end
        M_WAIT: begin
          m_run = ok ? m_run + 1 : 0;
          if (m_run == STABLE_CYCLES) begin
            m_phase = M_ACTIVE; m_up = 1;
          end
        end
        M_ACTIVE: begin
          if (dr) begin
            m_phase = M_DONE; m_finish = 1; m_up = 0;
          end else if (!ok) begin
            m_phase = M_WAIT; m_up = 0; m_drop = 1; m_run = 0;
          end
        end
        default: ;
      endcase
    end
    m_cycles = next_cycles;
  endtask

  // driver tasks
  task automatic drive(input logic rst, input logic [15:0] up, input logic [15:0] dn,
                       input logic [4:0] w, input logic rr, input logic dr);
    @(negedge Clk);
    Reset = rst; ElecIdleUp = up; ElecIdleDown = dn; LinkWidth = w;
    ReRstReq = rr; DoneReq = dr;
    model_step(rst, up, dn, w, rr, dr);
    exp_q.push_back({m_nres, m_up, m_drop, m_fatal, m_finish, 32'(m_cycles), phase_code(m_phase)});
  endtask

  task automatic do_reset(input int n);
    repeat (n) drive(1'b1, 16'h0, 16'h0, 5'd4, 1'b0, 1'b0);
  endtask

  task automatic run(input int n, input logic [15:0] up, input logic [15:0] dn, input logic [4:0] w);
    repeat (n) drive(1'b0, up, dn, w, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s sample %0d t=%0t: got %0h expected %0h", name, samples, $time, act, exp);
    end
  endtask

  // monitor: every clock edge produces an output vector to score
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(posedge Clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        samples++;
        check("notReset",   32'(notReset),  32'(e[39]));
        check("LinkUp",     32'(LinkUp),    32'(e[38]));
        check("LinkDrop",   32'(LinkDrop),  32'(e[37]));
        check("Fatal",      32'(Fatal),     32'(e[36]));
        check("Finish",     32'(Finish),    32'(e[35]));
        check("CycleCount", CycleCount,     e[34:3]);
        check("State",      32'(State),     32'(e[2:0]));
      end
    end
  end

  initial begin
    logic [15:0] r_up;
    logic [15:0] r_dn;
    int          wait_budget;
    Reset = 1'b1; ElecIdleUp = '0; ElecIdleDown = '0; LinkWidth = 5'd4;
    ReRstReq = 1'b0; DoneReq = 1'b0;

    // bring-up timing: hold release then stable run
    do_reset(3);
    run(25, 16'h0, 16'h0, 5'd4);

    // one-cycle idle on lane 2 at stable count 5 restarts the run
    do_reset(2);
    run(15, 16'h0, 16'h0, 5'd4);
    run(1, 16'h0, 16'h0004, 5'd4);
    run(20, 16'h0, 16'h0, 5'd4);

    // unmasked lane idle is ignored, masked lane idle drops the link
    do_reset(2);
    run(20, 16'h0, 16'h0, 5'd4);
    run(3, 16'h0200, 16'h0, 5'd4);
    run(2, 16'h0001, 16'h0, 5'd4);
    run(12, 16'h0, 16'h0, 5'd4);

    // width shrink/grow while active
    do_reset(1);
    run(20, 16'h0, 16'h0, 5'd2);
    run(2, 16'h0004, 16'h0, 5'd2);
    run(2, 16'h0004, 16'h0, 5'd16);
    run(10, 16'h8000, 16'h0, 5'd0);

    // re-reset and done in the same cycle: re-reset wins
    do_reset(2);
    run(20, 16'h0, 16'h0, 5'd4);
    drive(1'b0, 16'h0, 16'h0, 5'd4, 1'b1, 1'b1);
    run(22, 16'h0, 16'h0, 5'd4);

    // completion is terminal: no drop, no re-reset, no timeout afterwards
    do_reset(2);
    run(20, 16'h0, 16'h0, 5'd4);
    drive(1'b0, 16'h0, 16'h0, 5'd4, 1'b0, 1'b1);
    run(3, 16'h0001, 16'h0, 5'd4);
    drive(1'b0, 16'h0, 16'h0, 5'd4, 1'b1, 1'b0);
    run(40, 16'hFFFF, 16'hFFFF, 5'd4);

    // lanes never come up: timeout, then requests are ignored
    do_reset(2);
    run(40, 16'hFFFF, 16'hFFFF, 5'd4);
    for (int i = 0; i < 25; i++)
      drive(1'b0, 16'h0, 16'h0, 5'd4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // randomized segments, each starting from a reset (often mid-operation)
    for (int seg = 0; seg < 30; seg++) begin
      do_reset($urandom_range(1, 3));
      for (int c = 0; c < $urandom_range(20, 70); c++) begin
        r_up = ($urandom_range(0, 11) == 0) ? 16'($urandom()) : 16'h0;
        r_dn = ($urandom_range(0, 11) == 0) ? 16'($urandom()) : 16'h0;
        drive(1'b0, r_up, r_dn, 5'($urandom_range(0, 20)),
              1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 9) == 0));
      end
    end

    wait_budget = 10;
    while (exp_q.size() > 0 && wait_budget > 0) begin
      @(posedge Clk);
      #4;
      wait_budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
